// File: rtl/cmp_pkg.sv
// Shared types for the RGB compare LED block.
//   cmp_e   : committed/raw comparison code (NONE before the first commit).
//   state_e : two-state tracker (EMPTY until the first commit, then TRACK).
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_NONE = 2'b00,
    CMP_LT   = 2'b01,
    CMP_EQ   = 2'b10,
    CMP_GT   = 2'b11
  } cmp_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

endpackage

// File: rtl/rgb_compare_led_pwm_gen.sv
// Free-running PWM generator for the LED brightness.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   duty   : on-time in counts per 2^PWM_BITS-cycle period
//   pwm_on : high while the internal counter is below duty
module pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm_on
);

  logic [PWM_BITS-1:0] r_pwm_cnt;

  // Wraps naturally from all-ones back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  assign pwm_on = (r_pwm_cnt < duty);

endmodule

// File: rtl/rgb_compare_led.sv
// Glitch-filtered magnitude comparator driving the board RGB LED.
//   clk, rst_n  : clock, asynchronous active-low reset
//   sample_en   : sample a/b on this edge
//   signed_mode : 1 = two's-complement compare, 0 = unsigned
//   a, b        : operands
//   duty        : PWM on-time per period
//   result      : committed comparison (cmp_e)
//   changed     : one-cycle pulse when result takes a new value
//   R / G / B   : GT / EQ / LT indicators, PWM-gated, registered
// A comparison is committed only after HOLD_CYCLES consecutive identical
// samples; unsampled cycles neither extend nor break a run.
module rgb_compare_led
  import cmp_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int PWM_BITS    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic                signed_mode,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [PWM_BITS-1:0] duty,
  output logic [1:0]          result,
  output logic                changed,
  output logic                R,
  output logic                G,
  output logic                B
);

  localparam int              CNT_W  = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYCLES);

  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  cmp_e                    w_raw;

  cmp_e             r_cand;
  logic [CNT_W-1:0] r_cnt;
  cmp_e             r_result;
  logic             r_changed;
  logic             r_R;
  logic             r_G;
  logic             r_B;
  state_e           r_state;

  cmp_e             w_cand_n;
  logic [CNT_W-1:0] w_cnt_n;
  cmp_e             w_result_n;
  logic             w_commit;
  state_e           w_state_n;
  logic             w_led_en;
  logic             w_pwm_on;

  pwm_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .duty   (duty),
    .pwm_on (w_pwm_on)
  );

  // Raw comparison (combinational)
  assign w_a_s = a;
  assign w_b_s = b;

  always_comb begin
    w_raw = CMP_EQ;
    if (signed_mode) begin
      if (w_a_s > w_b_s) begin
        w_raw = CMP_GT;
      end else if (w_a_s < w_b_s) begin
        w_raw = CMP_LT;
      end
    end else begin
      if (a > b) begin
        w_raw = CMP_GT;
      end else if (a < b) begin
        w_raw = CMP_LT;
      end
    end
  end

  // Stability filter next-state
  // cand starts at NONE, which raw never produces, so the first sample
  // after reset always opens a fresh run at count 1.
  always_comb begin
    w_cand_n = r_cand;
    w_cnt_n  = r_cnt;
    w_commit = 1'b0;
    if (sample_en) begin
      if (w_raw != r_cand) begin
        w_cand_n = w_raw;
        w_cnt_n  = CNT_W'(1);
      end else if (r_cnt < HOLD_C) begin
        w_cnt_n = r_cnt + 1'b1;
      end
      w_commit = (w_cnt_n == HOLD_C) && (w_cand_n != r_result);
    end
    w_result_n = w_commit ? w_cand_n : r_result;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_n;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      ST_EMPTY: if (w_commit) w_state_n = ST_TRACK;
      ST_TRACK: w_state_n = ST_TRACK;
      default:  w_state_n = ST_EMPTY;
    endcase
  end

  // FSM: outputs. Keyed on the next state so the LEDs light on the very
  // edge that makes the first commit.
  always_comb begin
    w_led_en = 1'b0;
    unique case (w_state_n)
      ST_TRACK: w_led_en = 1'b1;
      default:  w_led_en = 1'b0;
    endcase
  end

  // Filter and LED registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand    <= CMP_NONE;
      r_cnt     <= '0;
      r_result  <= CMP_NONE;
      r_changed <= 1'b0;
      r_R       <= 1'b0;
      r_G       <= 1'b0;
      r_B       <= 1'b0;
    end else begin
      r_cand    <= w_cand_n;
      r_cnt     <= w_cnt_n;
      r_result  <= w_result_n;
      r_changed <= w_commit;
      r_R       <= w_led_en && w_pwm_on && (w_result_n == CMP_GT);
      r_G       <= w_led_en && w_pwm_on && (w_result_n == CMP_EQ);
      r_B       <= w_led_en && w_pwm_on && (w_result_n == CMP_LT);
    end
  end

  assign result  = r_result;
  assign changed = r_changed;
  assign R       = r_R;
  assign G       = r_G;
  assign B       = r_B;

endmodule

// File: tb/tb_rgb_compare_led.sv
// Self-checking bench for rgb_compare_led (WIDTH=4, HOLD_CYCLES=4, PWM_BITS=4).
module tb_rgb_compare_led;

  localparam int W = 4;
  localparam int H = 4;
  localparam int P = 4;

  localparam int C_NONE = 0;
  localparam int C_LT   = 1;
  localparam int C_EQ   = 2;
  localparam int C_GT   = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sample_en = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [P-1:0] duty = 4'hF;
  logic [1:0]   result;
  logic         changed;
  logic         R;
  logic         G;
  logic         B;

  always #5 clk = ~clk;

  rgb_compare_led #(
    .WIDTH       (W),
    .HOLD_CYCLES (H),
    .PWM_BITS    (P)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .duty        (duty),
    .result      (result),
    .changed     (changed),
    .R           (R),
    .G           (G),
    .B           (B)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: the current run of identical samples, the
  // committed result, and the number of clock edges since reset release.
  int m_run_val;
  int m_run_len;
  int m_result;
  int m_changed;
  int m_R;
  int m_G;
  int m_B;
  int m_pwm;

  typedef struct {
    logic         sm;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    int           exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int ref_cmp(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y);
    int xv;
    int yv;
    xv = int'(x);
    yv = int'(y);
    if (sm) begin
      if (xv >= 8) xv = xv - 16;
      if (yv >= 8) yv = yv - 16;
    end
    if (xv > yv) return C_GT;
    if (xv < yv) return C_LT;
    return C_EQ;
  endfunction

  task automatic model_reset();
    m_run_val = C_NONE;
    m_run_len = 0;
    m_result  = C_NONE;
    m_changed = 0;
    m_R = 0;
    m_G = 0;
    m_B = 0;
    m_pwm = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_result"},  int'(result),  m_result);
    check({tag, "_changed"}, int'(changed), m_changed);
    check({tag, "_R"},       int'(R),       m_R);
    check({tag, "_G"},       int'(G),       m_G);
    check({tag, "_B"},       int'(B),       m_B);
  endtask

  // One clock edge: model the edge from the inputs held across it, then
  // compare every output 1 time unit after the edge.
  task automatic tick();
    int   raw;
    int   pwm_pre;
    int   on;
    logic se;
    raw     = ref_cmp(signed_mode, a, b);
    pwm_pre = m_pwm;
    se      = sample_en;
    @(posedge clk);
    #1;
    if (rst_n) begin
      m_changed = 0;
      if (se) begin
        if (raw == m_run_val) begin
          m_run_len++;
        end else begin
          m_run_val = raw;
          m_run_len = 1;
        end
        if (m_run_len >= H && m_result != m_run_val) begin
          m_result  = m_run_val;
          m_changed = 1;
        end
      end
      on  = (pwm_pre < int'(duty)) ? 1 : 0;
      m_R = (on == 1 && m_result == C_GT) ? 1 : 0;
      m_G = (on == 1 && m_result == C_EQ) ? 1 : 0;
      m_B = (on == 1 && m_result == C_LT) ? 1 : 0;
      m_pwm = (m_pwm + 1) % (1 << P);
      check_outputs("tick");
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_result",  int'(result),  C_NONE);
    check("rst_changed", int'(changed), 0);
    check("rst_RGB",     int'({R, G, B}), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_in(input logic sm, input logic [W-1:0] va, input logic [W-1:0] vb, input logic se);
    signed_mode = sm;
    a           = va;
    b           = vb;
    sample_en   = se;
  endtask

  initial begin
    int first;
    int cnt_r;
    int cnt_g;
    int cnt_b;
    int pulses;

    model_reset();
    tbl[0] = '{1'b0, 4'd5, 4'd3, C_GT};
    tbl[1] = '{1'b0, 4'd9, 4'd9, C_EQ};
    tbl[2] = '{1'b0, 4'hF, 4'h1, C_GT};
    tbl[3] = '{1'b1, 4'hF, 4'h1, C_LT};
    tbl[4] = '{1'b1, 4'd7, 4'd8, C_GT};
    tbl[5] = '{1'b0, 4'd7, 4'd8, C_LT};
    tbl[6] = '{1'b1, 4'd0, 4'hF, C_GT};
    tbl[7] = '{1'b0, 4'd0, 4'hF, C_LT};
    tbl[8] = '{1'b1, 4'd5, 4'd5, C_EQ};
    tbl[9] = '{1'b1, 4'h8, 4'h7, C_LT};

    // 1: GT commit on the 4th edge, R at 15/16 brightness
    do_reset();
    set_in(1'b0, 4'd5, 4'd3, 1'b1);
    first = -1;
    cnt_r = 0; cnt_g = 0; cnt_b = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (changed && first < 0) first = i;
      if (i > 4) begin
        cnt_r += int'(R);
        cnt_g += int'(G);
        cnt_b += int'(B);
      end
    end
    check("t1_commit_edge", first, 4);
    check("t1_result", int'(result), C_GT);
    check("t1_R_on_count", cnt_r, 15);
    check("t1_GB_on_count", cnt_g + cnt_b, 0);

    // 2: one mismatching sample restarts the run
    do_reset();
    set_in(1'b0, 4'd9, 4'd9, 1'b1);
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 4) b = 4'd8;
      else        b = 4'd9;
      tick();
      if (changed && first < 0) first = i;
    end
    check("t2_commit_edge", first - 1, 7);
    check("t2_result", int'(result), C_EQ);

    // 3: signed_mode toggle flips GT to LT with exactly one pulse
    do_reset();
    set_in(1'b0, 4'hF, 4'h1, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("t3_unsigned", int'(result), C_GT);
    signed_mode = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      pulses += int'(changed);
    end
    check("t3_signed", int'(result), C_LT);
    check("t3_pulses", pulses, 1);

    // 4: gaps in sample_en do not break a run
    do_reset();
    set_in(1'b0, 4'd1, 4'd2, 1'b1);
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      sample_en = (i % 2 == 1);
      tick();
      if (changed && first < 0) first = i;
    end
    check("t4_commit_edge", first, 7);
    check("t4_result", int'(result), C_LT);

    // 5: duty controls brightness
    do_reset();
    set_in(1'b0, 4'd3, 4'd3, 1'b1);
    duty = 4'd0;
    for (int i = 0; i < 4; i++) tick();
    check("t5_result", int'(result), C_EQ);
    cnt_g = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      cnt_g += int'(G);
    end
    check("t5_duty0_G", cnt_g, 0);
    duty = 4'd8;
    tick();
    cnt_g = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      cnt_g += int'(G);
    end
    check("t5_duty8_G", cnt_g, 8);
    duty = 4'hF;

    // 6: reset mid-run, then mid-commit, then a full recommit
    do_reset();
    set_in(1'b0, 4'd5, 4'd3, 1'b1);
    tick();
    tick();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    check("t6_commit_pulse", int'(changed), 1);
    do_reset();
    first = -1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (changed && first < 0) first = i;
    end
    check("t6_recommit_edge", first, 4);

    // Table-driven vectors, each held for HOLD_CYCLES samples
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].sm, tbl[i].va, tbl[i].vb, 1'b1);
      for (int k = 0; k < H; k++) tick();
      check($sformatf("tbl%0d_result", i), int'(result), tbl[i].exp);
    end

    // Randomized run against the reference model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) begin
        signed_mode = 1'($urandom_range(1));
        a = 4'($urandom_range(15));
        b = ($urandom_range(2) == 0) ? a : 4'($urandom_range(15));
      end
      sample_en = ($urandom_range(4) != 0);
      if (i % 50 == 0) duty = 4'($urandom_range(15));
      if ($urandom_range(199) == 0) do_reset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_compare_led.md
# rgb_compare_led

Parametrised, glitch-filtered magnitude comparator driving the board RGB LED. It extends the 2×2-bit combinational compare-to-RGB block: WIDTH-bit operands, signed or unsigned compare, and a stability filter so that only a result held for HOLD_CYCLES consecutive samples is committed. Brightness is PWM-controlled. It sits between the switch/operand registers and the RGB LED pins.

## Interface
- WIDTH, 4: operand width in bits (≥1).
- HOLD_CYCLES, 4: consecutive identical samples required to commit a result (≥1; 1 = no filtering).
- PWM_BITS, 8: PWM counter and duty width (≥1).
- clk  in  1  system clock. Single clock domain; all state is on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- sample_en  in  1  when high, the comparator samples a/b this cycle.
- signed_mode  in  1  1: two's-complement compare. 0: unsigned compare.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- duty  in  PWM_BITS  LED on-time in counts per PWM period.
- result  out  2  committed result, encoded as cmp_e.
- changed  out  1  one-cycle pulse on the edge where `result` takes a new value.
- R  out  1  lit while result==GT, PWM-gated.
- G  out  1  lit while result==EQ, PWM-gated.
- B  out  1  lit while result==LT, PWM-gated.

## Operation
- raw = GT/EQ/LT from comparing a and b under signed_mode. This logic is combinational.
- Filter registers:
  - cand: cmp_e.
  - cnt: saturating, range 0..HOLD_CYCLES.
  - result: cmp_e.
- On a clock edge with sample_en=1:
  - If raw≠cand: cand←raw, cnt←1.
  - Else: cnt←min(cnt+1, HOLD_CYCLES).
  - If the next-state cnt==HOLD_CYCLES and the next-state cand≠result: result←next cand and changed←1.
- On an edge with sample_en=0: cand, cnt and result hold. A gap does not break a run. changed←0.
- FSM has two states:
  - EMPTY: after reset; result=NONE; LEDs dark.
  - TRACK: entered on the first commit; never leaves except through reset.
- A run that matches the already-committed result does not pulse changed.
- Toggling signed_mode mid-run can change raw. This is handled exactly like an operand change.
- PWM:
  - Free-running counter pwm_cnt, PWM_BITS wide, wraps at 2^PWM_BITS−1 → 0.
  - pwm_on = (pwm_cnt < duty).
  - duty=0: LEDs always dark. Maximum duty: on 2^PWM_BITS−1 of every 2^PWM_BITS cycles.
- R/G/B are registered: X ← (result==X_CODE) && pwm_on, using the next-state values.
- At most one of R/G/B is high in any cycle.

## Timing
- Reset values: result=NONE, cand=NONE, cnt=0, changed=0, R=G=B=0, pwm_cnt=0, FSM=EMPTY.
- Assertion is asynchronous. Release takes effect at the first rising edge after rst_n goes high.
- Commit latency: if stable raw is presented with sample_en=1 starting at edge k, result and changed update at edge k+HOLD_CYCLES−1. R/G/B reflect the new result at that same edge, subject to pwm_on.
- HOLD_CYCLES=1: result follows raw with a 1-edge latency on every sampled cycle.
- A mismatching sample at any point restarts the count at 1. There is no partial credit.
- Reset mid-run discards cand, cnt and result. No changed pulse is emitted on reset.

## Structure
- Shared package `cmp_pkg` contains:
  - typedef enum logic [1:0] cmp_e {CMP_NONE=2'b00, CMP_LT=2'b01, CMP_EQ=2'b10, CMP_GT=2'b11}.
  - FSM state enum {ST_EMPTY, ST_TRACK}.
- Sub-module `pwm_gen` (params PWM_BITS; ports clk, rst_n, duty, pwm_on) owns pwm_cnt. It is instantiated once.
- Compare, filter and FSM stay in the top module.

## Test plan
Bench parameters: WIDTH=4, HOLD_CYCLES=4, PWM_BITS=4, duty=4'hF unless stated.
- Reset, then a=5, b=3, unsigned, sample_en=1 held: result=GT and changed=1 exactly at the 4th edge. R toggles on 15 of every 16 cycles; G=B=0.
- Stable a=b=9 for 3 samples, then b=8 for 1 sample, then b=9 again: no commit until 4 consecutive samples of EQ. Commit lands 7 edges after the first sample.
- a=4'hF, b=4'h1: signed_mode=0 → GT. Then signed_mode=1 held for 4 samples → LT, with changed pulsing once.
- Stable LT with sample_en toggling 1,0,1,0,…: commit occurs after 4 sampled edges, i.e. 7 edges total.
- duty=0 with a committed EQ: G=0 throughout. duty=8: G high for 8 of every 16 cycles.
- rst_n pulsed low asynchronously mid-run and mid-commit: all outputs are 0/NONE immediately, with no changed pulse. Recommit takes a full 4 samples.
